axis_packer: RTL

Parametrised AXI-stream width up-converter: packs DATA_NB narrow 'up' words into one wide 'down' word, lane 0 first (rightmost), lane DATA_NB-1 last. It is the successor to the simple deserializer used on DMA and stream paths. It adds full valid/ready handshaking with back-pressure, partial-word flush on up_last with per-lane keep, and zero-fill of unused lanes. It sits between narrow producers (register/config streams, serial-ish cores) and the wide AXI-stream fabric.

---
 rtl/axis_packer_pkg.sv | 19 +
 rtl/axis_packer_out.sv | 79 +++++++
 rtl/axis_packer.sv | 115 +++++++++++
 3 files changed

// File: rtl/axis_packer_pkg.sv
// Shared sizing helpers for the AXI-stream packer. AXIS_PACKER_KEEP_EN is left
// undefined by default; define it at build time to add the per-lane keep output.
package axis_packer_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // The lane index needs at least one bit even when DATA_NB == 1.
    function automatic int idx_width(input int nb);
        return (clog2(nb) < 1) ? 1 : clog2(nb);
    endfunction

endpackage

// File: rtl/axis_packer_out.sv
// Down-side holding register of the packer (AXIS_PACKER_KEEP_EN adds keep): loads on 'load',
// one beat deep; 'free' is low while a beat is held and down_ready is low.
module axis_packer_out #(
    parameter int DATA_NB    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DATA_NB*DATA_WIDTH-1:0] load_data,
`ifdef AXIS_PACKER_KEEP_EN
    input  logic [DATA_NB-1:0]            load_keep,
`endif
    input  logic                          load_last,
    input  logic                          down_ready,
    output logic                          free,
    output logic                          down_valid,
    output logic [DATA_NB*DATA_WIDTH-1:0] down_data,
`ifdef AXIS_PACKER_KEEP_EN
    output logic [DATA_NB-1:0]            down_keep,
`endif
    output logic                          down_last
);

    logic                          valid_q, valid_d;
    logic [DATA_NB*DATA_WIDTH-1:0] data_q, data_d;
    logic                          last_q, last_d;
`ifdef AXIS_PACKER_KEEP_EN
    logic [DATA_NB-1:0]            keep_q, keep_d;
`endif

    assign free = ~valid_q | down_ready;

    // A load in the same cycle as a transfer keeps valid high: no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef AXIS_PACKER_KEEP_EN
        keep_d  = keep_q;
`endif
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
`ifdef AXIS_PACKER_KEEP_EN
            keep_d  = load_keep;
`endif
        end else if (down_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef AXIS_PACKER_KEEP_EN
            keep_q  <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef AXIS_PACKER_KEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

    assign down_valid = valid_q;
    assign down_data  = data_q;
    assign down_last  = last_q;
`ifdef AXIS_PACKER_KEEP_EN
    assign down_keep  = keep_q;
`endif

endmodule

// File: rtl/axis_packer.sv
// AXI-stream width up-converter, DATA_NB narrow beats -> one wide beat, lane 0 first; optional
// keep via AXIS_PACKER_KEEP_EN. Down beat valid the edge the completing beat is accepted; up_ready = ~down_valid | down_ready.
module axis_packer
    import axis_packer_pkg::*;
#(
    parameter int DATA_NB    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          up_ready,
    input  logic                          up_valid,
    input  logic [DATA_WIDTH-1:0]         up_data,
    input  logic                          up_last,
    input  logic                          down_ready,
    output logic                          down_valid,
    output logic [DATA_NB*DATA_WIDTH-1:0] down_data,
`ifdef AXIS_PACKER_KEEP_EN
    output logic [DATA_NB-1:0]            down_keep,
`endif
    output logic                          down_last
);

    localparam int IDX_W = idx_width(DATA_NB);
    localparam int W     = DATA_NB * DATA_WIDTH;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     asm_q, asm_d;
    logic [W-1:0]     load_data;
    logic             accept, complete, out_free;
`ifdef AXIS_PACKER_KEEP_EN
    logic [DATA_NB-1:0] asm_keep_q, asm_keep_d;
    logic [DATA_NB-1:0] load_keep;
`endif

    assign up_ready = out_free;
    assign accept   = up_valid & up_ready;
    assign complete = accept & (up_last | (idx_q == IDX_W'(DATA_NB - 1)));

    // Lanes above idx are masked by position, so stale assembly data never leaks out.
    always_comb begin
        asm_d     = asm_q;
        idx_d     = idx_q;
        load_data = '0;
`ifdef AXIS_PACKER_KEEP_EN
        asm_keep_d = asm_keep_q;
        load_keep  = asm_keep_q;
`endif
        for (int i = 0; i < DATA_NB; i++) begin
            if (i < int'(idx_q)) begin
                load_data[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (i == int'(idx_q)) begin
                load_data[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
`ifdef AXIS_PACKER_KEEP_EN
                load_keep[i] = 1'b1;
`endif
            end
        end
        if (complete) begin
            idx_d = '0;
`ifdef AXIS_PACKER_KEEP_EN
            asm_keep_d = '0;
`endif
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
            for (int i = 0; i < DATA_NB; i++) begin
                if (i == int'(idx_q)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
`ifdef AXIS_PACKER_KEEP_EN
                    asm_keep_d[i] = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            asm_q <= '0;
`ifdef AXIS_PACKER_KEEP_EN
            asm_keep_q <= '0;
`endif
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
`ifdef AXIS_PACKER_KEEP_EN
            asm_keep_q <= asm_keep_d;
`endif
        end
    end

    axis_packer_out #(
        .DATA_NB    (DATA_NB),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (load_data),
`ifdef AXIS_PACKER_KEEP_EN
        .load_keep  (load_keep),
`endif
        .load_last  (up_last),
        .down_ready (down_ready),
        .free       (out_free),
        .down_valid (down_valid),
        .down_data  (down_data),
`ifdef AXIS_PACKER_KEEP_EN
        .down_keep  (down_keep),
`endif
        .down_last  (down_last)
    );

endmodule
